// File: rtl/lpif_tx_arbiter_if.sv
// lpif_tx_arbiter_if: handshake and txfifo bundle for the LPIF transmit arbiter.
// Ports (DUT view, slave modport):
//   in : m_gen2_mode, req_a_valid/data, req_b_valid/data, tx_credit_return
//   out: req_a_ready, req_b_ready, txfifo_upstream_data/push, credit_count,
//        last_grant, credit_overflow
interface lpif_tx_arbiter_if #(
   parameter int DATA_WIDTH = 145
);
   logic                  m_gen2_mode;
   logic                  req_a_valid;
   logic [DATA_WIDTH-1:0] req_a_data;
   logic                  req_a_ready;
   logic                  req_b_valid;
   logic [DATA_WIDTH-1:0] req_b_data;
   logic                  req_b_ready;
   logic [DATA_WIDTH-1:0] txfifo_upstream_data;
   logic                  txfifo_upstream_push;
   logic                  tx_credit_return;
   logic [3:0]            credit_count;
   logic                  last_grant;
   logic                  credit_overflow;

   modport slave (
      input  m_gen2_mode, req_a_valid, req_a_data, req_b_valid, req_b_data, tx_credit_return,
      output req_a_ready, req_b_ready, txfifo_upstream_data, txfifo_upstream_push,
             credit_count, last_grant, credit_overflow
   );

   modport master (
      output m_gen2_mode, req_a_valid, req_a_data, req_b_valid, req_b_data, tx_credit_return,
      input  req_a_ready, req_b_ready, txfifo_upstream_data, txfifo_upstream_push,
             credit_count, last_grant, credit_overflow
   );
endinterface

// File: rtl/lpif_tx_arbiter.sv
// lpif_tx_arbiter: credit-gated round-robin arbiter of two requesters into the LPIF txfifo.
// Ports: clk_wr (clock), rst_wr (async active-high reset), bus (lpif_tx_arbiter_if.slave).
module lpif_tx_arbiter #(
   parameter int DATA_WIDTH = 145,
   parameter int CREDIT_MAX = 8
) (
   input logic               clk_wr,
   input logic               rst_wr,
   lpif_tx_arbiter_if.slave  bus
);
   localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

   typedef enum logic {ST_OPEN, ST_BUBBLE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            credit_q, credit_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  push_q, push_d;
   logic                  last_q, last_d;
   logic                  ovf_q, ovf_d;
   logic                  elig, grant_a, grant_b, grant, ret;

   // Ready is held low during reset so nothing is accepted and then discarded.
   assign elig    = !rst_wr && credit_q != 4'd0 && state_q == ST_OPEN;
   // On contention the source other than the last winner goes.
   assign grant_a = elig && bus.req_a_valid && (!bus.req_b_valid || last_q);
   assign grant_b = elig && bus.req_b_valid && (!bus.req_a_valid || !last_q);
   assign grant   = grant_a || grant_b;
   assign ret     = bus.tx_credit_return;

   always_comb begin
      state_d  = (grant && !bus.m_gen2_mode) ? ST_BUBBLE : ST_OPEN;
      credit_d = (grant && !ret) ? credit_q - 4'd1 :
                 (!grant && ret && credit_q != CMAX) ? credit_q + 4'd1 : credit_q;
      ovf_d    = ovf_q || (!grant && ret && credit_q == CMAX);
      data_d   = grant_a ? bus.req_a_data : grant_b ? bus.req_b_data : data_q;
      push_d   = grant;
      last_d   = grant ? grant_b : last_q;
   end

   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         state_q  <= ST_OPEN;
         credit_q <= CMAX;
         data_q   <= '0;
         push_q   <= 1'b0;
         last_q   <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         data_q   <= data_d;
         push_q   <= push_d;
         last_q   <= last_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.req_a_ready          = grant_a;
   assign bus.req_b_ready          = grant_b;
   assign bus.txfifo_upstream_data = data_q;
   assign bus.txfifo_upstream_push = push_q;
   assign bus.credit_count         = credit_q;
   assign bus.last_grant           = last_q;
   assign bus.credit_overflow      = ovf_q;
endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// tb_lpif_tx_arbiter: directed self-checking bench for lpif_tx_arbiter.
module tb_lpif_tx_arbiter;
   localparam int DW = 145;

   logic clk_wr = 1'b0;
   logic rst_wr = 1'b1;
   int   compared = 0;
   int   mismatched = 0;

   lpif_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   lpif_tx_arbiter #(.DATA_WIDTH(DW), .CREDIT_MAX(8)) dut (
      .clk_wr (clk_wr),
      .rst_wr (rst_wr),
      .bus    (bus)
   );

   always #5 clk_wr = ~clk_wr;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_wr);
      #1;
   endtask

   initial begin
      bus.m_gen2_mode      = 1'b1;
      bus.req_a_valid      = 1'b1;
      bus.req_b_valid      = 1'b1;
      bus.req_a_data       = DW'('h1A);
      bus.req_b_data       = DW'('h1B);
      bus.tx_credit_return = 1'b0;
      tick();
      tick();
      chk("rst_credit", DW'(bus.credit_count), DW'(8));
      chk("rst_push", DW'(bus.txfifo_upstream_push), DW'(0));
      chk("rst_data", bus.txfifo_upstream_data, DW'(0));
      chk("rst_last", DW'(bus.last_grant), DW'(1));
      chk("rst_ovf", DW'(bus.credit_overflow), DW'(0));
      chk("rst_ready_a", DW'(bus.req_a_ready), DW'(0));
      chk("rst_ready_b", DW'(bus.req_b_ready), DW'(0));
      rst_wr = 1'b0;
      #1;
      // Contention with 8 credits: A,B,A,B,...
      for (int i = 0; i < 8; i++) begin
         bus.req_a_data = DW'('hA0 + i);
         bus.req_b_data = DW'('hB0 + i);
         #1;
         chk("cont_ready_a", DW'(bus.req_a_ready), DW'(i % 2 == 0));
         chk("cont_ready_b", DW'(bus.req_b_ready), DW'(i % 2 == 1));
         tick();
         chk("cont_push", DW'(bus.txfifo_upstream_push), DW'(1));
         chk("cont_data", bus.txfifo_upstream_data, (i % 2 == 0) ? DW'('hA0 + i) : DW'('hB0 + i));
         chk("cont_last", DW'(bus.last_grant), DW'(i % 2));
         chk("cont_credit", DW'(bus.credit_count), DW'(7 - i));
      end
      chk("empty_ready_a", DW'(bus.req_a_ready), DW'(0));
      chk("empty_ready_b", DW'(bus.req_b_ready), DW'(0));
      tick();
      chk("empty_push", DW'(bus.txfifo_upstream_push), DW'(0));
      chk("empty_hold", bus.txfifo_upstream_data, DW'('hB7));
      chk("empty_credit", DW'(bus.credit_count), DW'(0));
      // Starvation: a returned credit is usable only on the following cycle
      bus.req_a_valid      = 1'b0;
      bus.req_b_data       = DW'('hC1);
      bus.tx_credit_return = 1'b1;
      #1;
      chk("starve_ready_b_same", DW'(bus.req_b_ready), DW'(0));
      tick();
      bus.tx_credit_return = 1'b0;
      #1;
      chk("starve_credit1", DW'(bus.credit_count), DW'(1));
      chk("starve_ready_b", DW'(bus.req_b_ready), DW'(1));
      tick();
      chk("starve_push", DW'(bus.txfifo_upstream_push), DW'(1));
      chk("starve_data", bus.txfifo_upstream_data, DW'('hC1));
      chk("starve_credit0", DW'(bus.credit_count), DW'(0));
      chk("starve_last", DW'(bus.last_grant), DW'(1));
      // Build to 3 credits, then grant and return together
      bus.req_b_valid      = 1'b0;
      bus.tx_credit_return = 1'b1;
      tick();
      tick();
      tick();
      chk("simul_pre", DW'(bus.credit_count), DW'(3));
      bus.req_b_valid = 1'b1;
      bus.req_b_data  = DW'('hD1);
      #1;
      chk("simul_ready_b", DW'(bus.req_b_ready), DW'(1));
      tick();
      chk("simul_credit", DW'(bus.credit_count), DW'(3));
      chk("simul_push", DW'(bus.txfifo_upstream_push), DW'(1));
      chk("simul_data", bus.txfifo_upstream_data, DW'('hD1));
      bus.tx_credit_return = 1'b0;
      // Gen1 pacing: ready toggles 1,0,1,0
      bus.m_gen2_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("gen1_ready_b", DW'(bus.req_b_ready), DW'(i % 2 == 0));
         tick();
         chk("gen1_push", DW'(bus.txfifo_upstream_push), DW'(i % 2 == 0));
      end
      chk("gen1_credit", DW'(bus.credit_count), DW'(1));
      bus.req_b_valid = 1'b0;
      bus.m_gen2_mode = 1'b1;
      // Fill credits back to the maximum, then overflow once
      bus.tx_credit_return = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("ovf_full", DW'(bus.credit_count), DW'(8));
      chk("ovf_clear", DW'(bus.credit_overflow), DW'(0));
      tick();
      chk("ovf_credit", DW'(bus.credit_count), DW'(8));
      chk("ovf_set", DW'(bus.credit_overflow), DW'(1));
      bus.tx_credit_return = 1'b0;
      tick();
      tick();
      chk("ovf_sticky", DW'(bus.credit_overflow), DW'(1));
      // Reset asserted mid-operation
      bus.req_a_valid = 1'b1;
      bus.req_b_valid = 1'b1;
      bus.req_a_data  = DW'('hA9);
      bus.req_b_data  = DW'('hB9);
      #1;
      chk("mid_ready_a", DW'(bus.req_a_ready), DW'(1));
      tick();
      chk("mid_push", DW'(bus.txfifo_upstream_push), DW'(1));
      chk("mid_last", DW'(bus.last_grant), DW'(0));
      #1;
      rst_wr = 1'b1;
      #1;
      chk("arst_push", DW'(bus.txfifo_upstream_push), DW'(0));
      chk("arst_credit", DW'(bus.credit_count), DW'(8));
      chk("arst_last", DW'(bus.last_grant), DW'(1));
      chk("arst_ovf", DW'(bus.credit_overflow), DW'(0));
      chk("arst_data", bus.txfifo_upstream_data, DW'(0));
      chk("arst_ready_b", DW'(bus.req_b_ready), DW'(0));
      tick();
      rst_wr = 1'b0;
      #1;
      chk("post_push", DW'(bus.txfifo_upstream_push), DW'(0));
      chk("post_ready_a", DW'(bus.req_a_ready), DW'(1));
      chk("post_ready_b", DW'(bus.req_b_ready), DW'(0));
      tick();
      chk("post_grant_push", DW'(bus.txfifo_upstream_push), DW'(1));
      chk("post_grant_data", bus.txfifo_upstream_data, DW'('hA9));
      chk("post_grant_last", DW'(bus.last_grant), DW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/lpif_tx_arbiter.md
LPIF_TX_ARBITER -- requirements
Module: lpif_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 145, SHALL set the txfifo word width in bits.
REQ-002 Parameter CREDIT_MAX, default 8, SHALL set the initial and maximum txfifo credit count (range 1..15).
REQ-003 clk_wr  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 rst_wr  input  1  SHALL be the reset: asynchronous assertion, active-high.
REQ-005 m_gen2_mode  input  1  SHALL select push rate: 1 = back-to-back pushes allowed, 0 = at most one push every two cycles.
REQ-006 req_a_valid  input  1  SHALL be the link-state requester (source A) valid.
REQ-007 req_a_data  input  DATA_WIDTH  SHALL be the source A word.
REQ-008 req_a_ready  output  1  SHALL be the source A accept.
REQ-009 req_b_valid  input  1  SHALL be the data requester (source B) valid.
REQ-010 req_b_data  input  DATA_WIDTH  SHALL be the source B word.
REQ-011 req_b_ready  output  1  SHALL be the source B accept.
REQ-012 txfifo_upstream_data  output  DATA_WIDTH  SHALL be the registered word pushed into the txfifo.
REQ-013 txfifo_upstream_push  output  1  SHALL be the one-cycle txfifo write strobe.
REQ-014 tx_credit_return  input  1  SHALL return one txfifo credit per high cycle.
REQ-015 credit_count  output  4  SHALL be the current available credit count.
REQ-016 last_grant  output  1  SHALL be the source of the most recent grant: 0 = A, 1 = B.
REQ-017 credit_overflow  output  1  SHALL be a sticky error flag.

Function
REQ-018 A transfer SHALL occur on a cycle when req_X_valid and req_X_ready are both high; ready is combinational from valid, credit_count, bubble, and last_grant.
REQ-019 The block SHALL be eligible to grant only when credit_count != 0 and the bubble flag is 0.
REQ-020 When eligible and exactly one source is valid, that source SHALL be granted.
REQ-021 When eligible and both sources are valid, the source not equal to last_grant SHALL be granted (round-robin).
REQ-022 When not eligible, both ready outputs SHALL be 0.
REQ-023 At most one ready SHALL be high in any cycle.
REQ-024 Ready SHALL NOT depend on the other source's ready; valid MAY drop without a grant, and no word is lost.
REQ-025 On a grant, txfifo_upstream_data SHALL load the granted word and txfifo_upstream_push SHALL be 1 in the next cycle (latency 1).
REQ-026 With no grant, txfifo_upstream_push SHALL be 0 in the next cycle, and txfifo_upstream_data SHALL hold its value.
REQ-027 On a grant, last_grant SHALL update to the granted source in the next cycle.
REQ-028 credit_count SHALL follow these rules each cycle:
 - decrement by 1 on a grant without tx_credit_return;
 - increment by 1 on tx_credit_return without a grant;
 - stay unchanged on simultaneous grant and return.
REQ-029 A return without a grant while credit_count == CREDIT_MAX SHALL leave the count at CREDIT_MAX and set credit_overflow, which stays set until reset.
REQ-030 When m_gen2_mode == 0, a grant SHALL set the bubble flag for exactly the next cycle; when m_gen2_mode == 1, the bubble flag SHALL remain 0.
REQ-031 A change of m_gen2_mode SHALL take effect on the next grant decision; an already-set bubble still completes.
REQ-032 A credit returned in cycle N SHALL be usable for a grant in cycle N+1, not in cycle N.

Reset
REQ-033 While rst_wr is high, the outputs and state SHALL be:
 - credit_count = CREDIT_MAX;
 - txfifo_upstream_push = 0;
 - txfifo_upstream_data = 0;
 - last_grant = 1 (so A wins the first contention);
 - bubble = 0;
 - credit_overflow = 0;
 - req_a_ready = 0 and req_b_ready = 0.
REQ-034 Reset asserted mid-transfer SHALL discard any pending push; no push strobe SHALL appear in the cycle after reset deasserts.
REQ-035 After reset deasserts, the first grant SHALL be possible on the first rising edge with rst_wr low.

Verification
REQ-036 Contention: gen2=1, A and B valid continuously, CREDIT_MAX=8, no returns -> grants A,B,A,B,A,B,A,B on consecutive cycles, then credit_count=0 and both ready stay 0.
REQ-037 Credit starvation: credit_count=0, pulse tx_credit_return one cycle with B valid -> credit_count=1 next cycle, B granted that cycle, push the cycle after, count back to 0.
REQ-038 Simultaneous grant and return: credit_count=3, grant and return in the same cycle -> credit_count remains 3.
REQ-039 Gen1 pacing: gen2=0, B valid continuously, credits ample -> req_b_ready toggles 1,0,1,0; push strobes occur every other cycle.
REQ-040 Overflow: credit_count=8, return pulse without grant -> count stays 8, credit_overflow=1 and remains 1 until rst_wr.
REQ-041 Reset mid-operation: rst_wr asserted asynchronously while a grant is pending -> push=0, credit_count=8, last_grant=1 immediately; first post-reset contention grants A.
